contadores_secuenciador: RTL and testbench

- Read-out controller for the per-FIFO pop counter bank (5 counters, 5-bit values), sitting between the counter bank and a host-side consumer.
- On a start request while the datapath is idle, drives req/idx through every counter index, captures each returned value, and hands it to the consumer over a valid/ready handshake.
- Per-counter response timeout; clean abort when the datapath leaves idle mid-sequence.

---
 rtl/contadores_pkg.sv | 18 +
 rtl/contadores_seq_wait_timer.sv | 34 +++
 rtl/contadores_secuenciador.sv | 203 ++++++++++++++++++++
 tb/tb_contadores_secuenciador.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contadores_pkg.sv
// Shared types and default sizing for the pop-counter read-out sequencer.
// The CONTADORES_SKIP_ZERO_EN build option is handled in contadores_secuenciador.
package contadores_pkg;

  localparam int NUM_CNT_DEF = 5;
  localparam int DW_DEF      = 5;
  localparam int IW_DEF      = 3;
  localparam int TIMEOUT_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/contadores_seq_wait_timer.sv
// Response timer for one counter read: loaded on clear, counts down while enabled,
// and flags the TIMEOUT-th enabled cycle through the combinational expires pulse.
module seq_wait_timer
  import contadores_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expires
);

  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - ONE;
    end
  end

  // Terminal count of 1 means this is the last silent cycle allowed.
  assign expires = enable && !clear && (count == ONE);

endmodule

// File: rtl/contadores_secuenciador.sv
// Read-out sequencer for the per-FIFO pop counter bank; every output is registered.
// Optional build macro CONTADORES_SKIP_ZERO_EN drops entries whose counter reads zero.
//
// state  | meaning
// S_IDLE | waiting for start while the datapath is idle
// S_REQ  | request issued for idx, response timer loaded
// S_WAIT | request held, waiting for cnt_valid or timeout
// S_PUSH | entry offered to the consumer until accepted
// S_DONE | one-cycle done pulse after the last index
module contadores_secuenciador
  import contadores_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int DW      = DW_DEF,
  parameter int IW      = IW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          IDLE,
  output logic          req,
  output logic [IW-1:0] idx,
  input  logic [DW-1:0] cnt_data,
  input  logic          cnt_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_err,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CNT - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state, state_nxt;
  logic          req_nxt;
  logic [IW-1:0] idx_nxt;
  logic          out_valid_nxt;
  logic [DW-1:0] out_data_nxt;
  logic [IW-1:0] out_idx_nxt;
  logic          out_err_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          abort_nxt;
  logic          tmr_clear;
  logic          tmr_en;
  logic          tmr_expires;
  logic          zero_skip;

`ifdef CONTADORES_SKIP_ZERO_EN
  assign zero_skip = (cnt_data == '0);
`else
  assign zero_skip = 1'b0;
`endif

  seq_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expires(tmr_expires)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      req       <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      req       <= req_nxt;
      idx       <= idx_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_idx   <= out_idx_nxt;
      out_err   <= out_err_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      abort     <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    idx_nxt       = idx;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_idx_nxt   = out_idx;
    out_err_nxt   = out_err;
    done_nxt      = 1'b0;
    abort_nxt     = 1'b0;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;

    unique case (state)
      S_IDLE: begin
        req_nxt = 1'b0;
        idx_nxt = '0;
        if (start && IDLE) begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
        end
      end

      S_REQ: begin
        tmr_clear = 1'b1;
        if (!IDLE) begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
          idx_nxt   = '0;
          abort_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!IDLE) begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
          idx_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt_valid && zero_skip) begin
          // Zero reading is dropped: move on without offering an entry.
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
            req_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
            idx_nxt   = idx + IDX_ONE;
          end
        end else if (cnt_valid) begin
          state_nxt     = S_PUSH;
          req_nxt       = 1'b0;
          out_valid_nxt = 1'b1;
          out_data_nxt  = cnt_data;
          out_idx_nxt   = idx;
          out_err_nxt   = 1'b0;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expires) begin
            state_nxt     = S_PUSH;
            req_nxt       = 1'b0;
            out_valid_nxt = 1'b1;
            out_data_nxt  = '0;
            out_idx_nxt   = idx;
            out_err_nxt   = 1'b1;
          end
        end
      end

      S_PUSH: begin
        req_nxt = 1'b0;
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          // A datapath that left idle during the offer stops the scan here.
          if (!IDLE) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            abort_nxt = 1'b1;
          end else if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
            req_nxt   = 1'b1;
            idx_nxt   = idx + IDX_ONE;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        idx_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        idx_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_contadores_secuenciador.sv
// Self-checking bench for contadores_secuenciador: cycle model of the scan rules,
// a latency-programmable counter bank, directed plan cases and randomized scans.
module tb_contadores_secuenciador;

  localparam int NUM_CNT = 5;
  localparam int DW      = 5;
  localparam int IW      = 3;
  localparam int TIMEOUT = 7;

`ifdef CONTADORES_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          IDLE = 1'b1;
  logic          req;
  logic [IW-1:0] idx;
  logic [DW-1:0] cnt_data = '0;
  logic          cnt_valid = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_err;
  logic          busy;
  logic          done;
  logic          abort;

  always #5 CLK = ~CLK;

  contadores_secuenciador #(
    .NUM_CNT(NUM_CNT), .DW(DW), .IW(IW), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .IDLE(IDLE),
    .req(req), .idx(idx), .cnt_data(cnt_data), .cnt_valid(cnt_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_err(out_err), .busy(busy), .done(done), .abort(abort)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Counter bank: answers a request after bank_dly[i] cycles (counted from the
  // first req cycle) and keeps answering while the request is held.
  int            bank_val[NUM_CNT];
  int            bank_dly[NUM_CNT];
  int            b_age = 0;
  logic          b_prev_req = 1'b0;
  logic [IW-1:0] b_prev_idx = '0;
  int            ready_mode = 0;
  int            rdy_wait = 0;

  always begin
    @(posedge CLK);
    #1;
    if (req === 1'b1 && idx < NUM_CNT) begin
      if (!b_prev_req || idx != b_prev_idx) b_age = 0;
      else b_age++;
      cnt_valid = (b_age >= bank_dly[idx]);
      cnt_data  = cnt_valid ? DW'(bank_val[idx]) : DW'($urandom);
    end else begin
      b_age     = 0;
      cnt_valid = 1'b0;
      cnt_data  = DW'($urandom);
    end
    b_prev_req = (req === 1'b1);
    b_prev_idx = idx;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (out_valid === 1'b1 && out_idx == 3'd2 && rdy_wait < 4) begin
          out_ready = 1'b0;
          rdy_wait++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b0;
    endcase
  end

  // Behavioural model: a scan walks positions 0..NUM_CNT-1; each position is
  // asked once, then either answered, timed out on the TIMEOUT-th silent cycle,
  // or (skip-zero builds) dropped when the answer is zero.
  bit            m_scan = 0;
  bit            m_hold = 0;
  bit            m_finish = 0;
  int            m_pos = 0;
  int            m_silent = 0;
  logic          e_done = 0;
  logic          e_abort = 0;
  logic [DW-1:0] e_data = '0;
  logic [IW-1:0] e_idx = '0;
  logic          e_err = 0;

  task automatic model_next_pos();
    if (!IDLE) begin
      m_scan  = 0;
      m_pos   = 0;
      e_abort = 1;
    end else if (m_pos == NUM_CNT - 1) begin
      m_finish = 1;
      e_done   = 1;
    end else begin
      m_pos++;
      m_silent = -1;
    end
  endtask

  task automatic model_offer(input logic [DW-1:0] d, input logic err);
    int exp_data;
    m_hold = 1;
    e_data = d;
    e_idx  = IW'(m_pos);
    e_err  = err;
    exp_data = (bank_dly[m_pos] > TIMEOUT) ? 0 : bank_val[m_pos];
    check("model_entry_vs_bank", {27'd0, d}, exp_data);
  endtask

  always @(posedge CLK) begin
    e_done  = 0;
    e_abort = 0;
    if (reset) begin
      m_scan = 0; m_hold = 0; m_finish = 0; m_pos = 0; m_silent = 0;
      e_data = '0; e_idx = '0; e_err = 0;
    end else if (!m_scan) begin
      if (start && IDLE) begin
        m_scan = 1; m_pos = 0; m_silent = -1;
      end
    end else if (m_finish) begin
      m_scan = 0; m_finish = 0; m_pos = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        model_next_pos();
      end
    end else if (!IDLE) begin
      m_scan = 0; m_pos = 0; e_abort = 1;
    end else if (m_silent < 0) begin
      m_silent = 0;
    end else if (cnt_valid && SKIP_ZERO && cnt_data == '0) begin
      model_next_pos();
    end else if (cnt_valid) begin
      model_offer(cnt_data, 1'b0);
    end else begin
      m_silent++;
      if (m_silent == TIMEOUT) model_offer('0, 1'b1);
    end
  end

  // Per-cycle compare plus entry/pulse logging.
  logic [IW-1:0] log_idx[$];
  logic [DW-1:0] log_data[$];
  logic          log_err[$];
  int            n_done = 0;
  int            n_abort = 0;
  logic          p_valid = 0, p_ready = 0, p_reset = 1, p_err = 0;
  logic [DW-1:0] p_data = '0;
  logic [IW-1:0] p_idx = '0;

  always @(negedge CLK) begin
    logic exp_req;
    exp_req = m_scan && !m_hold && !m_finish;
    check("req", req, exp_req);
    check("busy", busy, m_scan);
    check("done", done, e_done);
    check("abort", abort, e_abort);
    check("out_valid", out_valid, m_hold);
    if (exp_req) check("idx", idx, m_pos);
    if (m_hold) begin
      check("out_data", out_data, e_data);
      check("out_idx", out_idx, e_idx);
      check("out_err", out_err, e_err);
    end
    if (p_valid && !p_ready && !p_reset) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, p_data);
      check("hold_idx", out_idx, p_idx);
      check("hold_err", out_err, p_err);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      log_idx.push_back(out_idx);
      log_data.push_back(out_data);
      log_err.push_back(out_err);
    end
    if (done === 1'b1) n_done++;
    if (abort === 1'b1) n_abort++;
    p_valid = out_valid; p_ready = out_ready; p_reset = reset;
    p_data = out_data; p_idx = out_idx; p_err = out_err;
  end

  task automatic clear_log();
    log_idx.delete();
    log_data.delete();
    log_err.delete();
    n_done  = 0;
    n_abort = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ended = 0;
    for (int c = 0; c < budget; c++) begin
      if (busy === 1'b0) begin
        ended = 1;
        break;
      end
      tick();
    end
    check({name, "_ends"}, ended, 1);
  endtask

  task automatic set_bank(input int v0, v1, v2, v3, v4, input int dly);
    bank_val[0] = v0; bank_val[1] = v1; bank_val[2] = v2;
    bank_val[3] = v3; bank_val[4] = v4;
    for (int i = 0; i < NUM_CNT; i++) bank_dly[i] = dly;
  endtask

  task automatic check_log(input string name, input int n, input int ei[5], input int ed[5], input int ee[5]);
    check({name, "_count"}, log_idx.size(), n);
    for (int i = 0; i < n && i < log_idx.size(); i++) begin
      check({name, "_idx"}, log_idx[i], ei[i]);
      check({name, "_data"}, log_data[i], ed[i]);
      check({name, "_err"}, log_err[i], ee[i]);
    end
  endtask

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation did not terminate, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ei[5], ed[5], ee[5];
    int n_exp;
    int drop;
    bit hold;
    set_bank(0, 0, 0, 0, 0, 2);
    tick(3);
    reset = 1'b0;
    check("rst_req", req, 0);
    check("rst_idx", idx, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    tick(2);

    // Full scan with values 3,0,7,31,1 answered two cycles after each request.
    set_bank(3, 0, 7, 31, 1, 2);
    ready_mode = 0;
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_req_latency", req, 1);
    check("t1_first_idx", idx, 0);
    wait_idle("t1", 200);
    tick(2);
    if (SKIP_ZERO) begin
      n_exp = 4;
      ei = '{0, 2, 3, 4, 0}; ed = '{3, 7, 31, 1, 0};
    end else begin
      n_exp = 5;
      ei = '{0, 1, 2, 3, 4}; ed = '{3, 0, 7, 31, 1};
    end
    ee = '{0, 0, 0, 0, 0};
    check_log("t1", n_exp, ei, ed, ee);
    check("t1_done_pulses", n_done, 1);
    check("t1_abort_pulses", n_abort, 0);

    // Backpressure: consumer stalls four cycles on idx 2.
    set_bank(4, 8, 15, 16, 23, 2);
    ready_mode = 2;
    rdy_wait = 0;
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("t2", 200);
    tick(2);
    check("t2_stall_cycles", rdy_wait, 4);
    ei = '{0, 1, 2, 3, 4}; ed = '{4, 8, 15, 16, 23};
    check_log("t2", 5, ei, ed, ee);
    check("t2_done_pulses", n_done, 1);

    // Timeouts on idx 1 (silent) and idx 4 (one cycle late); idx 3 answers on the deadline.
    set_bank(5, 9, 12, 20, 30, 2);
    bank_dly[1] = 100;
    bank_dly[3] = TIMEOUT;
    bank_dly[4] = TIMEOUT + 1;
    ready_mode = 0;
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("t3", 300);
    tick(2);
    ei = '{0, 1, 2, 3, 4}; ed = '{5, 0, 12, 20, 0}; ee = '{0, 1, 0, 0, 1};
    check_log("t3", 5, ei, ed, ee);
    check("t3_done_pulses", n_done, 1);

    // Abort: datapath leaves idle while idx 3 is waiting for its answer.
    set_bank(6, 10, 14, 18, 22, 3);
    ready_mode = 0;
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (req === 1'b1 && idx == 3'd3) break;
      tick();
    end
    check("t4_reached_idx3", {req, idx}, {1'b1, 3'd3});
    tick();
    IDLE = 1'b0;
    tick();
    check("t4_req_dropped", req, 0);
    check("t4_abort_now", abort, 1);
    IDLE = 1'b1;
    tick(3);
    check("t4_abort_pulses", n_abort, 1);
    check("t4_done_pulses", n_done, 0);
    ee = '{0, 0, 0, 0, 0};
    ei = '{0, 1, 2, 0, 0}; ed = '{6, 10, 14, 0, 0};
    check_log("t4", 3, ei, ed, ee);
    IDLE = 1'b0;
    start = 1'b1;
    tick(3);
    check("t4_start_busy_datapath_req", req, 0);
    check("t4_start_busy_datapath_busy", busy, 0);
    start = 1'b0;
    IDLE = 1'b1;
    tick(2);
    check("t4_start_not_latched", busy, 0);

    // Reset while an entry is being offered, then a clean scan from idx 0.
    set_bank(1, 2, 3, 4, 5, 1);
    ready_mode = 3;
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid === 1'b1) break;
      tick();
    end
    check("t5_offer_seen", out_valid, 1);
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_req", req, 0);
    check("t5_idx", idx, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_out_idx", out_idx, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_abort", abort, 0);
    ready_mode = 0;
    tick(2);
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    check("t5_restart_idx", idx, 0);
    wait_idle("t5", 200);
    tick(2);
    ei = '{0, 1, 2, 3, 4}; ed = '{1, 2, 3, 4, 5};
    check_log("t5", 5, ei, ed, ee);
    check("t5_done_pulses", n_done, 1);

    // Randomized scans: random values/latencies/consumer, occasional aborts, held start.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        bank_val[i] = $urandom_range(0, 31);
        bank_dly[i] = $urandom_range(0, 9);
      end
      ready_mode = 1;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
      hold = (drop < 0) && ($urandom_range(0, 1) == 1);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (c == drop) IDLE = 1'b0;
        if (c == drop + 2) IDLE = 1'b1;
        if (busy === 1'b0 && (drop < 0 || c > drop + 2)) break;
        tick();
      end
      start = 1'b0;
      IDLE = 1'b1;
      wait_idle("rand", 400);
      tick(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
